// File: rtl/up2_pkg.sv
// up2_pkg: constants and types shared by the up2 memory arbiter, its
// round-robin picker and the up2_mem swap units.
//   ARB_IDLE / ARB_BUSY : arbiter lock state encoding
//   UP2_*_NIBBLES       : default address / data widths in nibbles
//   UP2_TXN_ACKS        : acks in one swap transaction (read, write, read)
`timescale 1ns/1ps
package up2_pkg;

  localparam int unsigned UP2_ADDR_NIBBLES = 1;
  localparam int unsigned UP2_DATA_NIBBLES = 1;
  localparam int unsigned UP2_TXN_ACKS     = 3;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/up2_rr_pick.sv
// up2_rr_pick: combinational round-robin picker.
//   pending     : one bit per requester
//   rr_ptr      : index of the last winner; search starts at rr_ptr+1
//   winner      : first pending index in rr_ptr+1, rr_ptr+2, ... mod NUM_REQ
//   any_pending : at least one pending bit set (winner is meaningless if 0)
`timescale 1ns/1ps
module up2_rr_pick
  import up2_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   pending,
  input  logic [IDX_WIDTH-1:0] rr_ptr,
  output logic [IDX_WIDTH-1:0] winner,
  output logic                 any_pending
);

  localparam logic [IDX_WIDTH:0] NUM_REQ_W = (IDX_WIDTH+1)'(NUM_REQ);

  // Scan from the farthest candidate down to rr_ptr+1 so the nearest pending
  // index is the last one written and therefore wins.
  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it holding its old value (which would infer a latch).
  always_comb begin
    logic [IDX_WIDTH:0] cand;
    winner = rr_ptr;
    cand   = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = {1'b0, rr_ptr} + (IDX_WIDTH+1)'(i);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (pending[cand[IDX_WIDTH-1:0]]) winner = cand[IDX_WIDTH-1:0];
    end
  end

  assign any_pending = |pending;

endmodule

// File: rtl/up2_mem_arb.sv
// up2_mem_arb: round-robin arbiter sharing one memory handshake port between
// NUM_REQ up2_mem swap units. A grant is locked for TXN_ACKS forwarded acks
// so one unit's read/write/read swap is never interleaved with another's.
//   i_req_read_req/i_req_write_req : per-requester level requests
//   i_req_addr/i_req_data          : flattened, requester k at [k*W +: W]
//   o_req_read_ack/o_req_write_ack : acks routed to the granted requester only
//   o_req_data                     : memory read data, broadcast
//   o_read_req/o_write_req/o_addr/o_data, i_read_ack/i_write_ack/i_data :
//                                    memory-side handshake
//   o_grant : one-hot grant (0 when idle)   o_busy : transaction locked
//   o_abort : one-cycle pulse when the granted requester walks away
`timescale 1ns/1ps
module up2_mem_arb
  import up2_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int IDX_WIDTH    = 2,
  parameter int ADDR_NIBBLES = UP2_ADDR_NIBBLES,
  parameter int DATA_NIBBLES = UP2_DATA_NIBBLES,
  parameter int ADDR_WIDTH   = 4*ADDR_NIBBLES,
  parameter int DATA_WIDTH   = 4*DATA_NIBBLES,
  parameter int TXN_ACKS     = UP2_TXN_ACKS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            i_req_read_req,
  input  logic [NUM_REQ-1:0]            i_req_write_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_read_ack,
  output logic [NUM_REQ-1:0]            o_req_write_ack,
  output logic [DATA_WIDTH-1:0]         o_req_data,
  output logic                          o_read_req,
  input  logic                          i_read_ack,
  output logic                          o_write_req,
  input  logic                          i_write_ack,
  output logic [ADDR_WIDTH-1:0]         o_addr,
  output logic [DATA_WIDTH-1:0]         o_data,
  input  logic [DATA_WIDTH-1:0]         i_data,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_busy,
  output logic                          o_abort
);

  localparam logic [1:0] LAST_ACK = 2'(TXN_ACKS-1);

  arb_state_e           state, state_n;
  logic [IDX_WIDTH-1:0] gnt_idx, gnt_idx_n;
  logic [IDX_WIDTH-1:0] rr_ptr, rr_ptr_n;
  logic [IDX_WIDTH-1:0] winner;
  logic [1:0]           ack_cnt, ack_cnt_n;
  logic                 abort_n;
  logic                 any_pending;
  logic [NUM_REQ-1:0]   pending;
  logic                 gnt_rd, gnt_wr;
  logic                 fwd_ack;

  assign pending = i_req_read_req | i_req_write_req;
  assign gnt_rd  = i_req_read_req[gnt_idx];
  assign gnt_wr  = i_req_write_req[gnt_idx];

  up2_rr_pick #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_pick (
    .pending     (pending),
    .rr_ptr      (rr_ptr),
    .winner      (winner),
    .any_pending (any_pending)
  );

  // State register. rr_ptr resets to the last index so requester 0 wins first.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; the reset is synchronous, so it sits inside the edge block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARB_IDLE;
      gnt_idx <= '0;
      rr_ptr  <= IDX_WIDTH'(NUM_REQ-1);
      ack_cnt <= '0;
      o_abort <= 1'b0;
    end else begin
      state   <= state_n;
      gnt_idx <= gnt_idx_n;
      rr_ptr  <= rr_ptr_n;
      ack_cnt <= ack_cnt_n;
      o_abort <= abort_n;
    end
  end

  // Next-state logic. Leaving BUSY always passes through IDLE, which gives the
  // one idle cycle between grants and makes the releaser lowest priority.
  always_comb begin
    state_n   = state;
    gnt_idx_n = gnt_idx;
    rr_ptr_n  = rr_ptr;
    ack_cnt_n = ack_cnt;
    abort_n   = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (any_pending) begin
          state_n   = ARB_BUSY;
          gnt_idx_n = winner;
          rr_ptr_n  = winner;
          ack_cnt_n = '0;
        end
      end
      ARB_BUSY: begin
        if (fwd_ack) begin
          if (ack_cnt == LAST_ACK) begin
            state_n   = ARB_IDLE;
            ack_cnt_n = '0;
          end else begin
            ack_cnt_n = ack_cnt + 2'd1;
          end
        end else if (!gnt_rd && !gnt_wr) begin
          // Granted unit dropped its swap mid-way: release the lock.
          state_n   = ARB_IDLE;
          ack_cnt_n = '0;
          abort_n   = 1'b1;
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  // Output logic: pure combinational forwarding, no registers in the
  // request, ack or data paths. Read wins if a unit raises both requests.
  always_comb begin
    o_grant         = '0;
    o_read_req      = 1'b0;
    o_write_req     = 1'b0;
    o_req_read_ack  = '0;
    o_req_write_ack = '0;
    o_addr          = i_req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    o_data          = i_req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    o_req_data      = i_data;
    if (state == ARB_BUSY) begin
      o_grant[gnt_idx]         = 1'b1;
      o_read_req               = gnt_rd;
      o_write_req              = gnt_wr & ~gnt_rd;
      o_req_read_ack[gnt_idx]  = i_read_ack & o_read_req;
      o_req_write_ack[gnt_idx] = i_write_ack & o_write_req;
    end
  end

  // Acks arriving without the matching request are neither routed nor counted.
  assign fwd_ack = (o_read_req & i_read_ack) | (o_write_req & i_write_ack);
  assign o_busy  = (state == ARB_BUSY);

endmodule

// File: tb/tb_up2_mem_arb.sv
// Self-checking bench for up2_mem_arb: swap-unit requesters and a one-cycle
// memory responder driven from directed scenarios, a behavioural model of the
// arbitration rules compared on every falling edge, and literal expectations
// for the scenario outcomes (grant orders, ack counts, abort pulses).
`timescale 1ns/1ps
module tb_up2_mem_arb;

  localparam int NR  = 4;
  localparam int AW  = 4;
  localparam int DW  = 4;
  localparam int TXN = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    i_req_read_req, i_req_write_req;
  logic [NR*AW-1:0] i_req_addr;
  logic [NR*DW-1:0] i_req_data;
  logic [NR-1:0]    o_req_read_ack, o_req_write_ack;
  logic [DW-1:0]    o_req_data;
  logic             o_read_req, i_read_ack, o_write_req, i_write_ack;
  logic [AW-1:0]    o_addr;
  logic [DW-1:0]    o_data, i_data;
  logic [NR-1:0]    o_grant;
  logic             o_busy, o_abort;

  up2_mem_arb #(
    .NUM_REQ(NR), .IDX_WIDTH(2), .ADDR_NIBBLES(1), .DATA_NIBBLES(1),
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TXN_ACKS(TXN)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req_read_req(i_req_read_req), .i_req_write_req(i_req_write_req),
    .i_req_addr(i_req_addr), .i_req_data(i_req_data),
    .o_req_read_ack(o_req_read_ack), .o_req_write_ack(o_req_write_ack),
    .o_req_data(o_req_data),
    .o_read_req(o_read_req), .i_read_ack(i_read_ack),
    .o_write_req(o_write_req), .i_write_ack(i_write_ack),
    .o_addr(o_addr), .o_data(o_data), .i_data(i_data),
    .o_grant(o_grant), .o_busy(o_busy), .o_abort(o_abort)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- requester / memory stimulus ----------------
  // phase: 0 idle, 1 first read, 2 write, 3 final read
  int         phase [NR];
  int         rep   [NR];
  bit         abort_after [NR];
  logic [3:0] addr_tab [NR];
  logic [3:0] data_tab [NR];
  bit         stray_wr;
  logic       cap_rd, cap_wr;
  logic [NR-1:0] cap_rack, cap_wack;
  int         cyc = 0;

  task automatic apply_reqs();
    for (int k = 0; k < NR; k++) begin
      i_req_read_req[k]      = (phase[k] == 1) || (phase[k] == 3);
      i_req_write_req[k]     = (phase[k] == 2);
      i_req_addr[k*AW +: AW] = addr_tab[k];
      i_req_data[k*DW +: DW] = data_tab[k];
    end
  endtask

  // One clock: sample handshake at the falling edge, drive new inputs 1ns
  // after the rising edge. Memory acks one cycle after it sees a request.
  task automatic step();
    @(negedge clk);
    cap_rd   = o_read_req;
    cap_wr   = o_write_req;
    cap_rack = o_req_read_ack;
    cap_wack = o_req_write_ack;
    @(posedge clk);
    #1;
    for (int k = 0; k < NR; k++) begin
      if ((phase[k] == 1 || phase[k] == 3) && cap_rack[k]) begin
        if (phase[k] == 3) begin
          if (rep[k] > 0) begin rep[k]--; phase[k] = 1; end
          else phase[k] = 0;
        end else if (abort_after[k]) begin
          abort_after[k] = 1'b0;
          phase[k] = 0;
        end else begin
          phase[k] = 2;
        end
      end else if (phase[k] == 2 && cap_wack[k]) begin
        phase[k] = 3;
      end
    end
    i_read_ack  = cap_rd && !i_read_ack;
    i_write_ack = (cap_wr && !i_write_ack) || stray_wr;
    stray_wr    = 1'b0;
    i_data      = 4'(cyc * 7 + 3);
    cyc++;
    apply_reqs();
  endtask

  function automatic bit any_active();
    bit a = 1'b0;
    for (int k = 0; k < NR; k++) if (phase[k] != 0) a = 1'b1;
    return a;
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    while ((any_active() || o_busy) && n < 200) begin
      step();
      n++;
    end
    check({name, " finished"}, 32'(n < 200), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < NR; k++) begin phase[k] = 0; rep[k] = 0; abort_after[k] = 1'b0; end
    apply_reqs();
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  int   m_owner = -1, m_taken = 0, m_last = NR-1;
  bit   m_abort = 1'b0, mvalid = 1'b0;
  int   busy_cycles = 0, abort_pulses = 0;
  int   fwd_acks [NR];
  int   glog[$];
  logic [NR-1:0] prev_grant = '0;
  logic [NR-1:0] e_grant, e_rack, e_wack, pend;
  bit   e_busy, e_rd, e_wr, found;

  always @(negedge clk) begin
    if (mvalid) begin
      e_busy  = (m_owner >= 0);
      e_grant = '0; e_rack = '0; e_wack = '0;
      e_rd = 1'b0; e_wr = 1'b0;
      if (e_busy) begin
        e_grant[m_owner] = 1'b1;
        e_rd = i_req_read_req[m_owner];
        e_wr = i_req_write_req[m_owner] && !e_rd;
        if (e_rd && i_read_ack)  e_rack[m_owner] = 1'b1;
        if (e_wr && i_write_ack) e_wack[m_owner] = 1'b1;
      end
      check("o_grant",         32'(o_grant),         32'(e_grant));
      check("o_busy",          32'(o_busy),          32'(e_busy));
      check("o_read_req",      32'(o_read_req),      32'(e_rd));
      check("o_write_req",     32'(o_write_req),     32'(e_wr));
      check("o_req_read_ack",  32'(o_req_read_ack),  32'(e_rack));
      check("o_req_write_ack", 32'(o_req_write_ack), 32'(e_wack));
      check("o_abort",         32'(o_abort),         32'(m_abort));
      check("o_req_data",      32'(o_req_data),      32'(i_data));
      if (e_busy) begin
        check("o_addr", 32'(o_addr), 32'(i_req_addr[m_owner*AW +: AW]));
        check("o_data", 32'(o_data), 32'(i_req_data[m_owner*DW +: DW]));
      end
      if (o_busy)  busy_cycles++;
      if (o_abort) abort_pulses++;
      for (int k = 0; k < NR; k++)
        if (o_req_read_ack[k] || o_req_write_ack[k]) fwd_acks[k]++;
      if (o_grant != '0 && o_grant != prev_grant) glog.push_back(int'($clog2(o_grant)));
      prev_grant = o_grant;
    end
    // advance the model across the coming rising edge
    if (rst) begin
      m_owner = -1; m_taken = 0; m_last = NR-1; m_abort = 1'b0; mvalid = 1'b1;
    end else if (mvalid) begin
      m_abort = 1'b0;
      if (m_owner < 0) begin
        pend  = i_req_read_req | i_req_write_req;
        found = 1'b0;
        for (int j = 1; j <= NR; j++) begin
          if (!found && pend[(m_last + j) % NR]) begin
            found   = 1'b1;
            m_owner = (m_last + j) % NR;
          end
        end
        if (found) begin m_last = m_owner; m_taken = 0; end
      end else if ((e_rd && i_read_ack) || (e_wr && i_write_ack)) begin
        m_taken++;
        if (m_taken == TXN) begin m_owner = -1; m_taken = 0; end
      end else if (!i_req_read_req[m_owner] && !i_req_write_req[m_owner]) begin
        m_owner = -1; m_taken = 0; m_abort = 1'b1;
      end
    end
  end

  function automatic int glog_at(input int i);
    return (i < glog.size()) ? glog[i] : -1;
  endfunction

  // ---------------- directed scenarios ----------------
  int b0, a0, f0;
  bit seen;

  initial begin
    rst = 1'b1; i_read_ack = 1'b0; i_write_ack = 1'b0; i_data = '0; stray_wr = 1'b0;
    for (int k = 0; k < NR; k++) begin
      addr_tab[k] = 4'(4'hA + k); data_tab[k] = 4'(k + 1); fwd_acks[k] = 0;
    end
    addr_tab[2] = 4'h5;
    do_reset();

    // reset state
    #2;
    check("reset o_grant",     32'(o_grant),     32'h0);
    check("reset o_busy",      32'(o_busy),      32'h0);
    check("reset o_abort",     32'(o_abort),     32'h0);
    check("reset o_read_req",  32'(o_read_req),  32'h0);
    check("reset o_write_req", 32'(o_write_req), 32'h0);

    // single requester 2 swap at 0x5
    b0 = busy_cycles; f0 = fwd_acks[2];
    phase[2] = 1; apply_reqs();
    step(); #2;
    check("single grant",    32'(o_grant),        32'b0100);
    check("single rd_req",   32'(o_read_req),     32'h1);
    check("single addr",     32'(o_addr),         32'h5);
    step(); #2;
    check("single rd ack1",  32'(o_req_read_ack), 32'b0100);
    step(); #2;
    check("single wr_req",   32'(o_write_req),    32'h1);
    step(); #2;
    check("single wr ack",   32'(o_req_write_ack), 32'b0100);
    step(); step(); #2;
    check("single rd ack2",  32'(o_req_read_ack), 32'b0100);
    check("single busy end", 32'(o_busy),         32'h1);
    step(); #2;
    check("single released", 32'(o_busy),         32'h0);
    check("single busy cyc", 32'(busy_cycles - b0), 32'd6);
    check("single acks",     32'(fwd_acks[2] - f0), 32'd3);

    // contention 0,1,3 right after reset
    do_reset();
    glog.delete();
    phase[0] = 1; phase[1] = 1; phase[3] = 1; apply_reqs();
    wait_idle("contention");
    check("cont n grants", 32'(glog.size()), 32'd3);
    check("cont g0", 32'(glog_at(0)), 32'd0);
    check("cont g1", 32'(glog_at(1)), 32'd1);
    check("cont g2", 32'(glog_at(2)), 32'd3);

    // fairness: 0 re-requests at release while 1 waits
    glog.delete();
    phase[0] = 1; rep[0] = 1; phase[1] = 1; apply_reqs();
    wait_idle("fairness");
    check("fair n grants", 32'(glog.size()), 32'd3);
    check("fair g0", 32'(glog_at(0)), 32'd0);
    check("fair g1", 32'(glog_at(1)), 32'd1);
    check("fair g2", 32'(glog_at(2)), 32'd0);

    // stray write ack in the first BUSY cycle
    b0 = busy_cycles; f0 = fwd_acks[2];
    phase[2] = 1; apply_reqs();
    stray_wr = 1'b1;
    step(); #2;
    check("stray wr ack", 32'(o_req_write_ack), 32'h0);
    wait_idle("stray");
    check("stray busy cyc", 32'(busy_cycles - b0), 32'd6);
    check("stray acks",     32'(fwd_acks[2] - f0), 32'd3);

    // abort: 3 walks away after first read ack, 0 is next
    glog.delete(); a0 = abort_pulses;
    phase[3] = 1; abort_after[3] = 1'b1; phase[0] = 1; apply_reqs();
    wait_idle("abort");
    check("abort pulses", 32'(abort_pulses - a0), 32'd1);
    check("abort g0", 32'(glog_at(0)), 32'd3);
    check("abort g1", 32'(glog_at(1)), 32'd0);

    // reset in the middle of requester 1's swap, after its write ack
    phase[1] = 1; apply_reqs();
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      step();
      seen = cap_wack[1];
    end
    check("rst wr ack seen", 32'(seen), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    glog.delete();
    phase[1] = 0; phase[0] = 1; phase[2] = 1; apply_reqs();
    #2;
    check("rst o_grant",    32'(o_grant),        32'h0);
    check("rst o_read_req", 32'(o_read_req),     32'h0);
    check("rst o_abort",    32'(o_abort),        32'h0);
    check("rst rd ack",     32'(o_req_read_ack), 32'h0);
    wait_idle("post reset");
    check("rst g0", 32'(glog_at(0)), 32'd0);
    check("rst g1", 32'(glog_at(1)), 32'd2);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
